// File: rtl/apb_ucpd_bmc_enc.sv
// apb_ucpd_bmc_enc: USB-PD BMC line encoder (preamble, 4b5b symbol stream, tail).
// Ports:
//   ic_clk, ic_rst_n      processor clock, async active-low reset
//   hbit_clk_red          one-cycle half-bit tick from the clock generator
//   tx_start, tx_abort    one-cycle frame start / abort requests
//   sym_data/valid/last   5-bit coded symbol (LSB first) with ready/valid handshake
//   sym_ready             holding register can accept a symbol
//   bmc_out, bmc_en       registered line level, frame-active enable
//   tx_done/underrun/aborted  one-cycle status pulses
module apb_ucpd_bmc_enc (
    input  logic       ic_clk,
    input  logic       ic_rst_n,
    input  logic       hbit_clk_red,
    input  logic       tx_start,
    input  logic       tx_abort,
    input  logic [4:0] sym_data,
    input  logic       sym_valid,
    input  logic       sym_last,
    output logic       sym_ready,
    output logic       bmc_out,
    output logic       bmc_en,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       tx_aborted
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;
    state_t     state, state_nxt;
    logic       hp;
    logic [5:0] bit_cnt;
    logic [4:0] shreg;
    logic [2:0] bidx;
    logic       cur_last;
    logic [4:0] hold_data;
    logic       hold_last, hold_full, last_acc;
    logic       tick_end, load, underrun, done, aborted, xfer, bit_val;
    // hp is held at 0 in IDLE, so this is only ever a second-half tick of an active frame
    assign tick_end = hbit_clk_red & hp;
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        underrun  = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        if (state == IDLE) begin
            if (tx_start && !tx_abort) state_nxt = PREAMBLE;
        end else if (tx_abort) begin
            aborted   = 1'b1;
            state_nxt = IDLE;
        end else if (tick_end) begin
            if (state == TAIL) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end else if ((state == PREAMBLE && bit_cnt == 6'd63) || (state == DATA && bidx == 3'd4)) begin
                // symbol boundary: finish, reload from the holding register, or starve
                if (state == DATA && cur_last) state_nxt = TAIL;
                else if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = DATA;
                end else begin
                    underrun  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end
    always_comb begin
        bmc_en    = state != IDLE;
        sym_ready = !hold_full && !last_acc && (state == PREAMBLE || state == DATA);
        xfer      = sym_valid && sym_ready;
        bit_val   = state == PREAMBLE ? bit_cnt[0] : shreg[0];
    end
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            bmc_out     <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_aborted  <= 1'b0;
            hp          <= 1'b0;
            bit_cnt     <= 6'd0;
            shreg       <= 5'd0;
            bidx        <= 3'd0;
            cur_last    <= 1'b0;
            hold_data   <= 5'd0;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
            last_acc    <= 1'b0;
        end else begin
            tx_done     <= done;
            tx_underrun <= underrun;
            tx_aborted  <= aborted;
            // bit boundary always toggles; mid-bit toggles only for a 1
            if (aborted || underrun || done) bmc_out <= 1'b0;
            else if (hbit_clk_red && state != IDLE) bmc_out <= bmc_out ^ (!hp | bit_val);
            hp      <= (state == IDLE || state_nxt == IDLE) ? 1'b0 : hp ^ hbit_clk_red;
            bit_cnt <= state == IDLE ? 6'd0 :
                       (state == PREAMBLE && tick_end && bit_cnt != 6'd63) ? bit_cnt + 6'd1 : bit_cnt;
            if (load) begin
                shreg    <= hold_data;
                bidx     <= 3'd0;
                cur_last <= hold_last;
            end else if (state == DATA && tick_end && bidx != 3'd4) begin
                shreg <= shreg >> 1;
                bidx  <= bidx + 3'd1;
            end
            // the load above sees the old holding contents even when a new symbol lands this edge
            if (state_nxt == IDLE) begin
                hold_full <= 1'b0;
                last_acc  <= 1'b0;
            end else begin
                if (xfer) begin
                    hold_data <= sym_data;
                    hold_last <= sym_last;
                    hold_full <= 1'b1;
                end else if (load) hold_full <= 1'b0;
                last_acc <= last_acc | (xfer & sym_last);
            end
        end
    end
endmodule

// File: tb/tb_apb_ucpd_bmc_enc.sv
// tb_apb_ucpd_bmc_enc: directed table-driven bench for the BMC encoder.
module tb_apb_ucpd_bmc_enc;
    logic       ic_clk = 1'b0, ic_rst_n = 1'b0, hbit_clk_red = 1'b0, tx_start = 1'b0, tx_abort = 1'b0;
    logic [4:0] sym_data = 5'd0;
    logic       sym_valid = 1'b0, sym_last = 1'b0;
    logic       sym_ready, bmc_out, bmc_en, tx_done, tx_underrun, tx_aborted;
    int checks = 0, failures = 0;
    int n_done = 0, n_und = 0, n_abt = 0;
    logic [4:0] fd [4];
    logic       fl [4];
    int nsym = 0, fi = 0;
    logic rdy_q = 1'b0;
    typedef struct {
        logic [4:0] sym;
        logic       start_mid;
        logic [0:9] lv;
        logic       tail_mid;
    } vec_t;
    vec_t tbl [5];
    logic [0:7] pat;
    apb_ucpd_bmc_enc dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .hbit_clk_red(hbit_clk_red),
        .tx_start(tx_start), .tx_abort(tx_abort), .sym_data(sym_data),
        .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready),
        .bmc_out(bmc_out), .bmc_en(bmc_en), .tx_done(tx_done),
        .tx_underrun(tx_underrun), .tx_aborted(tx_aborted)
    );
    always #5 ic_clk = ~ic_clk;
    always @(negedge ic_clk) begin
        if (tx_done) n_done++;
        if (tx_underrun) n_und++;
        if (tx_aborted) n_abt++;
    end
    // symbol source: presents fd/fl entries in order, advancing after each transfer
    initial begin
        forever begin
            @(negedge ic_clk);
            if (sym_valid && rdy_q) fi++;
            sym_valid = fi < nsym;
            sym_data  = fd[fi < 4 ? fi : 3];
            sym_last  = fl[fi < 4 ? fi : 3];
            rdy_q     = sym_ready;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask
    task automatic half();
        repeat (3) @(negedge ic_clk);
        hbit_clk_red = 1'b1;
        @(negedge ic_clk);
        hbit_clk_red = 1'b0;
    endtask
    task automatic start();
        tx_start = 1'b1;
        @(negedge ic_clk);
        tx_start = 1'b0;
    endtask
    task automatic run_preamble(input string nm);
        int perr;
        perr = 0;
        for (int k = 0; k < 128; k++) begin
            half();
            if (k == 0) chk({nm, "_first_tick"}, bmc_out, 1);
            if (bmc_out !== pat[k % 8]) perr++;
        end
        chk({nm, "_preamble_errs"}, perr, 0);
    endtask
    initial begin
        int base_d, base_u, base_a;
        pat = 8'b11010010;
        tbl[0] = '{5'b10101, 1'b1, 10'b1011010010, 1'b1};
        tbl[1] = '{5'b00000, 1'b0, 10'b1100110011, 1'b0};
        tbl[2] = '{5'b11111, 1'b0, 10'b1010101010, 1'b1};
        tbl[3] = '{5'b00001, 1'b0, 10'b1011001100, 1'b1};
        tbl[4] = '{5'b11000, 1'b0, 10'b1100110101, 1'b0};
        for (int i = 0; i < 4; i++) begin
            fd[i] = 5'd0;
            fl[i] = 1'b0;
        end
        repeat (3) @(negedge ic_clk);
        chk("reset_outs", {bmc_out, bmc_en, sym_ready, tx_done, tx_underrun, tx_aborted}, 0);
        ic_rst_n = 1'b1;
        repeat (2) @(negedge ic_clk);
        for (int v = 0; v < 5; v++) begin
            nsym = 1; fi = 0; fd[0] = tbl[v].sym; fl[0] = 1'b1;
            base_d = n_done; base_u = n_und;
            start();
            chk($sformatf("v%0d_bmc_en", v), bmc_en, 1);
            run_preamble($sformatf("v%0d", v));
            for (int k = 0; k < 10; k++) begin
                if (tbl[v].start_mid && k == 3) start();
                half();
                chk($sformatf("v%0d_data_hb%0d", v, k), bmc_out, tbl[v].lv[k]);
            end
            half();
            chk($sformatf("v%0d_tail_mid", v), bmc_out, tbl[v].tail_mid);
            half();
            chk($sformatf("v%0d_tail_end", v), {bmc_out, tx_done}, 2'b01);
            repeat (2) @(negedge ic_clk);
            chk($sformatf("v%0d_idle", v), {bmc_en, tx_done}, 0);
            chk($sformatf("v%0d_done_cnt", v), n_done - base_d, 1);
            chk($sformatf("v%0d_und_cnt", v), n_und - base_u, 0);
            nsym = 0; fi = 0;
            repeat (2) @(negedge ic_clk);
        end
        nsym = 2; fi = 0; fd[0] = 5'b00000; fl[0] = 1'b0; fd[1] = 5'b11111; fl[1] = 1'b0;
        base_d = n_done; base_u = n_und;
        start();
        for (int k = 0; k < 148; k++) begin
            half();
            if (k == 146) chk("und_not_early", {bmc_en, n_und - base_u}, 33'h1_0000_0000);
        end
        chk("und_pulse", {tx_underrun, bmc_out, bmc_en}, 3'b100);
        chk("und_syms_taken", fi, 2);
        repeat (3) @(negedge ic_clk);
        chk("und_cnt", n_und - base_u, 1);
        chk("und_no_done", n_done - base_d, 0);
        nsym = 0; fi = 0;
        repeat (2) @(negedge ic_clk);
        base_a = n_abt;
        start();
        for (int k = 0; k < 41; k++) half();
        chk("abt_pre_state", {bmc_en, sym_ready}, 2'b11);
        tx_abort = 1'b1;
        @(negedge ic_clk);
        tx_abort = 1'b0;
        chk("abt_next", {bmc_out, bmc_en, tx_aborted, sym_ready}, 4'b0010);
        repeat (4) half();
        chk("abt_stays_idle", {bmc_out, bmc_en}, 0);
        chk("abt_cnt", n_abt - base_a, 1);
        base_d = n_done; base_u = n_und; base_a = n_abt;
        tx_start = 1'b1; tx_abort = 1'b1;
        @(negedge ic_clk);
        tx_start = 1'b0; tx_abort = 1'b0;
        chk("start_abort_idle", bmc_en, 0);
        repeat (2) half();
        chk("start_abort_still_idle", {bmc_en, bmc_out}, 0);
        chk("start_abort_no_pulses", (n_done - base_d) + (n_und - base_u) + (n_abt - base_a), 0);
        nsym = 1; fi = 0; fd[0] = 5'b10101; fl[0] = 1'b1;
        start();
        for (int k = 0; k < 133; k++) half();
        chk("rst_pre_bmc_en", bmc_en, 1);
        #2 ic_rst_n = 1'b0;
        #1 chk("rst_async_outs", {bmc_out, bmc_en, sym_ready, tx_done, tx_underrun, tx_aborted}, 0);
        @(negedge ic_clk);
        nsym = 0; fi = 0;
        ic_rst_n = 1'b1;
        repeat (4) half();
        chk("rst_resume_idle", {bmc_en, bmc_out, sym_ready}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
